// File: rtl/pipelined_addsub_if.sv
// Handshake/operand bundle between an issue-side producer and the pipelined adder/subtractor.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  // Producer/consumer side
  modport master (
    output in_valid, in_sub, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  // Arithmetic block side
  modport slave (
    input  in_valid, in_sub, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the ripple carry chain is cut into STAGES
// segments with a register between segments and a valid/ready handshake on both ends.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_aL,
  pipelined_addsub_if.slave  bus
);

  localparam int unsigned SEG  = (WIDTH + STAGES - 1) / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Per-stage registers: valid, mode, running carry, carry into MSB, sums, operands
  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic              r_sub [STAGES];
  logic              r_cm  [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic              r_ovf;
  logic              r_zero;

  // Stage inputs (previous register or the operand port) and stage results
  logic [STAGES-1:0] w_src_v;
  logic [STAGES-1:0] w_src_c;
  logic              w_src_sub [STAGES];
  logic              w_src_cm  [STAGES];
  logic [WIDTH-1:0]  w_src_sum [STAGES];
  logic [WIDTH-1:0]  w_src_a   [STAGES];
  logic [WIDTH-1:0]  w_src_b   [STAGES];

  logic [STAGES-1:0] w_c;
  logic              w_cm  [STAGES];
  logic [WIDTH-1:0]  w_sum [STAGES];
  logic [STAGES-1:0] w_en;
  logic              w_ovf;
  logic              w_zero;

  // Stage 0 takes the operand port (b pre-inverted for subtract); later stages take the previous register
  for (genvar s = 0; s < STAGES; s++) begin : g_src
    if (s == 0) begin : g_first
      assign w_src_v[s]   = bus.in_valid;
      assign w_src_sub[s] = bus.in_sub;
      assign w_src_c[s]   = bus.in_sub;
      assign w_src_cm[s]  = 1'b0;
      assign w_src_sum[s] = '0;
      assign w_src_a[s]   = bus.in_a;
      assign w_src_b[s]   = bus.in_b ^ {WIDTH{bus.in_sub}};
    end else begin : g_next
      assign w_src_v[s]   = r_v[s-1];
      assign w_src_sub[s] = r_sub[s-1];
      assign w_src_c[s]   = r_c[s-1];
      assign w_src_cm[s]  = r_cm[s-1];
      assign w_src_sum[s] = r_sum[s-1];
      assign w_src_a[s]   = r_a[s-1];
      assign w_src_b[s]   = r_b[s-1];
    end
  end

  // Ripple full-adder chain over each stage's own segment; empty segments pass through
  always_comb begin : seg_ripple
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             cm;
    w_c    = '0;
    w_ovf  = 1'b0;
    w_zero = 1'b1;
    for (int unsigned s = 0; s < STAGES; s++) begin
      sum = w_src_sum[s];
      c   = w_src_c[s];
      cm  = w_src_cm[s];
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if ((i >= s * SEG) && (i < (s + 1) * SEG)) begin
          if (i == WIDTH - 1) cm = c;
          sum[i] = w_src_a[s][i] ^ w_src_b[s][i] ^ c;
          c      = (w_src_a[s][i] & w_src_b[s][i]) | (c & (w_src_a[s][i] ^ w_src_b[s][i]));
        end
      end
      w_sum[s] = sum;
      w_c[s]   = c;
      w_cm[s]  = cm;
    end
    w_ovf  = w_cm[LAST] ^ w_c[LAST];
    w_zero = ~|w_sum[LAST];
  end

  // Stage k may load when out_ready is high or any stage from k to the end is empty
  always_comb begin : stage_enable
    logic full;
    full = 1'b1;
    w_en = '0;
    for (int s = int'(LAST); s >= 0; s--) begin
      full    = full & r_v[s];
      w_en[s] = bus.out_ready | ~full;
    end
  end

  // Pipeline registers; reset empties every stage and presents a zero result
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_v    <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
      for (int s = 0; s < int'(STAGES); s++) begin
        r_sub[s] <= 1'b0;
        r_cm[s]  <= 1'b0;
        r_sum[s] <= '0;
        r_a[s]   <= '0;
        r_b[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < int'(STAGES); s++) begin
        if (w_en[s]) begin
          r_v[s]   <= w_src_v[s];
          r_sub[s] <= w_src_sub[s];
          r_c[s]   <= w_c[s];
          r_cm[s]  <= w_cm[s];
          r_sum[s] <= w_sum[s];
          r_a[s]   <= w_src_a[s];
          r_b[s]   <= w_src_b[s];
        end
      end
      if (w_en[LAST]) begin
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign bus.in_ready  = w_en[0];
  assign bus.out_valid = r_v[LAST];
  assign bus.out_sum   = r_sum[LAST];
  assign bus.out_cout  = r_c[LAST];
  assign bus.out_ovf   = r_ovf;
  assign bus.out_zero  = r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub across several WIDTH/STAGES configurations.
module tb_pipelined_addsub;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_aL;

  int   n_vec   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  int   acc0    = 0;
  bit   lat_chk = 1'b0;
  exp_t sb [5][$];
  exp_t dq [$];

  pipelined_addsub_if #(.WIDTH(8))  b0 ();
  pipelined_addsub_if #(.WIDTH(8))  b1 ();
  pipelined_addsub_if #(.WIDTH(8))  b2 ();
  pipelined_addsub_if #(.WIDTH(8))  b3 ();
  pipelined_addsub_if #(.WIDTH(32)) b4 ();

  pipelined_addsub #(.WIDTH(8),  .STAGES(2)) u0 (.clk(clk), .rst_aL(rst_aL), .bus(b0));
  pipelined_addsub #(.WIDTH(8),  .STAGES(1)) u1 (.clk(clk), .rst_aL(rst_aL), .bus(b1));
  pipelined_addsub #(.WIDTH(8),  .STAGES(3)) u2 (.clk(clk), .rst_aL(rst_aL), .bus(b2));
  pipelined_addsub #(.WIDTH(8),  .STAGES(8)) u3 (.clk(clk), .rst_aL(rst_aL), .bus(b3));
  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u4 (.clk(clk), .rst_aL(rst_aL), .bus(b4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [31:0] sum, input logic cout, input logic ovf, input logic zero);
    exp_t e;
    e.sum = sum; e.cout = cout; e.ovf = ovf; e.zero = zero; e.cyc = 0;
    return e;
  endfunction

  // Reference arithmetic on w-bit two's complement values
  function automatic exp_t model(input int w, input logic sub, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] mask, aa, bb, full;
    exp_t e;
    mask  = (33'd1 << w) - 33'd1;
    aa    = {1'b0, a} & mask;
    bb    = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full  = aa + bb + 33'(sub);
    e.sum  = 32'(full & mask);
    e.cout = full[w];
    e.zero = ((full & mask) == 33'd0);
    e.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s u%0d: observed %0h expected %0h", tag, id, obs, expv);
    end
  endtask

  task automatic mon(input int id, input int w, input int stg, input logic ifire, input logic ofire,
                     input logic sub, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] osum, input logic ocout, input logic oovf, input logic ozero);
    exp_t e;
    if (ofire) begin
      n_vec++;
      assert (sb[id].size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_out u%0d: observed %0h expected no result", id, osum);
      end
      if (sb[id].size() != 0) begin
        e = sb[id].pop_front();
        chk("sum",  id, osum,        e.sum);
        chk("cout", id, 32'(ocout),  32'(e.cout));
        chk("ovf",  id, 32'(oovf),   32'(e.ovf));
        chk("zero", id, 32'(ozero),  32'(e.zero));
        if (lat_chk) chk("latency", id, 32'(cyc - e.cyc), 32'(stg));
      end
    end
    if (ifire) begin
      if (id == 0) acc0++;
      if (id == 0 && dq.size() != 0) e = dq.pop_front();
      else e = model(w, sub, a, b);
      e.cyc = cyc;
      sb[id].push_back(e);
    end
  endtask

  // Sample all handshakes mid-cycle, then move to the next falling edge
  task automatic step();
    #1;
    mon(0, 8, 2, b0.in_valid & b0.in_ready, b0.out_valid & b0.out_ready, b0.in_sub,
        32'(b0.in_a), 32'(b0.in_b), 32'(b0.out_sum), b0.out_cout, b0.out_ovf, b0.out_zero);
    mon(1, 8, 1, b1.in_valid & b1.in_ready, b1.out_valid & b1.out_ready, b1.in_sub,
        32'(b1.in_a), 32'(b1.in_b), 32'(b1.out_sum), b1.out_cout, b1.out_ovf, b1.out_zero);
    mon(2, 8, 3, b2.in_valid & b2.in_ready, b2.out_valid & b2.out_ready, b2.in_sub,
        32'(b2.in_a), 32'(b2.in_b), 32'(b2.out_sum), b2.out_cout, b2.out_ovf, b2.out_zero);
    mon(3, 8, 8, b3.in_valid & b3.in_ready, b3.out_valid & b3.out_ready, b3.in_sub,
        32'(b3.in_a), 32'(b3.in_b), 32'(b3.out_sum), b3.out_cout, b3.out_ovf, b3.out_zero);
    mon(4, 32, 4, b4.in_valid & b4.in_ready, b4.out_valid & b4.out_ready, b4.in_sub,
        b4.in_a, b4.in_b, b4.out_sum, b4.out_cout, b4.out_ovf, b4.out_zero);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_all();
    b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.out_ready = 1'b1;
    b3.in_valid = 1'b0; b3.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.out_ready = 1'b1;
  endtask

  task automatic drive_all(input bit vld_rand, input bit rdy_rand);
    b0.in_valid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    b0.in_sub = 1'($urandom); b0.in_a = 8'($urandom); b0.in_b = 8'($urandom);
    b0.out_ready = rdy_rand ? 1'($urandom) : 1'b1;
    b1.in_valid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    b1.in_sub = 1'($urandom); b1.in_a = 8'($urandom); b1.in_b = 8'($urandom);
    b1.out_ready = rdy_rand ? 1'($urandom) : 1'b1;
    b2.in_valid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    b2.in_sub = 1'($urandom); b2.in_a = 8'($urandom); b2.in_b = 8'($urandom);
    b2.out_ready = rdy_rand ? 1'($urandom) : 1'b1;
    b3.in_valid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    b3.in_sub = 1'($urandom); b3.in_a = 8'($urandom); b3.in_b = 8'($urandom);
    b3.out_ready = rdy_rand ? 1'($urandom) : 1'b1;
    b4.in_valid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    b4.in_sub = 1'($urandom); b4.in_a = 32'($urandom); b4.in_b = 32'($urandom);
    b4.out_ready = rdy_rand ? 1'($urandom) : 1'b1;
  endtask

  // Present one op on u0 until accepted (bounded)
  task automatic send0(input logic sub, input logic [7:0] a, input logic [7:0] b);
    int n0;
    n0 = acc0;
    b0.in_valid = 1'b1; b0.in_sub = sub; b0.in_a = a; b0.in_b = b;
    for (int k = 0; k < 20 && acc0 == n0; k++) step();
    b0.in_valid = 1'b0;
    chk("accept", 0, 32'(acc0 - n0), 32'd1);
  endtask

  task automatic drain();
    idle_all();
    for (int k = 0; k < 64; k++) begin
      if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size() != 0) step();
    end
    for (int id = 0; id < 5; id++) chk("drain_empty", id, 32'(sb[id].size()), 32'd0);
  endtask

  initial begin
    int n0;
    idle_all();
    b0.in_sub = 1'b0; b0.in_a = '0; b0.in_b = '0;
    b1.in_sub = 1'b0; b1.in_a = '0; b1.in_b = '0;
    b2.in_sub = 1'b0; b2.in_a = '0; b2.in_b = '0;
    b3.in_sub = 1'b0; b3.in_a = '0; b3.in_b = '0;
    b4.in_sub = 1'b0; b4.in_a = '0; b4.in_b = '0;

    // Reset state
    rst_aL = 1'b1;
    #1 rst_aL = 1'b0;
    #2;
    chk("rst_out_valid", 0, 32'(b0.out_valid), 32'd0);
    chk("rst_in_ready",  0, 32'(b0.in_ready),  32'd1);
    chk("rst_sum",       0, 32'(b0.out_sum),   32'd0);
    chk("rst_cout",      0, 32'(b0.out_cout),  32'd0);
    chk("rst_ovf",       0, 32'(b0.out_ovf),   32'd0);
    chk("rst_zero",      0, 32'(b0.out_zero),  32'd1);
    chk("rst_zero",      4, 32'(b4.out_zero),  32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_aL = 1'b1;

    // 1: single add, latency 2
    lat_chk = 1'b1;
    dq.push_back(mk(32'h41, 1'b0, 1'b0, 1'b0));
    send0(1'b0, 8'h3C, 8'h05);
    drain();

    // 2: directed subtract/overflow/wrap cases back to back
    dq.push_back(mk(32'hFE, 1'b0, 1'b0, 1'b0));
    dq.push_back(mk(32'h7F, 1'b1, 1'b1, 1'b0));
    dq.push_back(mk(32'h80, 1'b0, 1'b1, 1'b0));
    dq.push_back(mk(32'h00, 1'b1, 1'b0, 1'b1));
    send0(1'b1, 8'h05, 8'h07);
    send0(1'b1, 8'h80, 8'h01);
    send0(1'b0, 8'h7F, 8'h01);
    send0(1'b0, 8'hFF, 8'h01);
    drain();

    // 3: 16 back-to-back random ops, full throughput
    n0 = acc0;
    for (int k = 0; k < 16; k++) begin
      b0.in_valid = 1'b1; b0.in_sub = 1'($urandom); b0.in_a = 8'($urandom); b0.in_b = 8'($urandom);
      step();
    end
    b0.in_valid = 1'b0;
    chk("stream_accepts", 0, 32'(acc0 - n0), 32'd16);
    drain();

    // 4: backpressure fills exactly STAGES slots, outputs hold, then drain in order
    lat_chk = 1'b0;
    b0.out_ready = 1'b0;
    n0 = acc0;
    for (int k = 0; k < 5; k++) begin
      b0.in_valid = 1'b1; b0.in_sub = 1'($urandom); b0.in_a = 8'($urandom); b0.in_b = 8'($urandom);
      step();
    end
    chk("stall_accepts", 0, 32'(acc0 - n0), 32'd2);
    chk("stall_in_ready", 0, 32'(b0.in_ready), 32'd0);
    chk("stall_out_valid", 0, 32'(b0.out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      b0.in_sub = 1'($urandom); b0.in_a = 8'($urandom); b0.in_b = 8'($urandom);
      step();
    end
    chk("hold_sum",  0, 32'(b0.out_sum),  sb[0][0].sum);
    chk("hold_cout", 0, 32'(b0.out_cout), 32'(sb[0][0].cout));
    chk("hold_ovf",  0, 32'(b0.out_ovf),  32'(sb[0][0].ovf));
    chk("hold_zero", 0, 32'(b0.out_zero), 32'(sb[0][0].zero));
    chk("hold_valid", 0, 32'(b0.out_valid), 32'd1);
    drain();

    // 5: asynchronous reset with two ops in flight
    b0.out_ready = 1'b0;
    send0(1'b0, 8'h11, 8'h22);
    send0(1'b1, 8'h33, 8'h01);
    chk("inflight_valid", 0, 32'(b0.out_valid), 32'd1);
    #2 rst_aL = 1'b0;
    #1;
    chk("async_out_valid", 0, 32'(b0.out_valid), 32'd0);
    chk("async_in_ready",  0, 32'(b0.in_ready),  32'd1);
    chk("async_sum",       0, 32'(b0.out_sum),   32'd0);
    chk("async_zero",      0, 32'(b0.out_zero),  32'd1);
    for (int id = 0; id < 5; id++) sb[id].delete();
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    rst_aL = 1'b1;
    b0.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("post_rst_valid", 0, 32'(b0.out_valid), 32'd0);
    lat_chk = 1'b1;
    send0(1'b0, 8'h12, 8'h34);
    drain();

    // 6a: all configurations, continuous streams, latency checked
    for (int k = 0; k < 12; k++) begin
      drive_all(1'b0, 1'b0);
      step();
    end
    drain();

    // 6b: random valid and random out_ready
    lat_chk = 1'b0;
    for (int k = 0; k < 80; k++) begin
      drive_all(1'b1, 1'b1);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
